// File: rtl/uart_pkg.sv
// Shared types and constants for the UART port responder.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 96;
   localparam int UART_DATA_W          = 8;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_deserializer.sv
// Serial receiver: synchronizes rxd, finds the start bit, samples each bit at
// mid-bit and reports a completed byte or a framing error for one cycle.
module uart_rx_deserializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                   clk11,
   input  logic                   rst,
   input  logic                   rxd,
   output logic                   byte_valid,
   output logic [UART_DATA_W-1:0] rx_byte,
   output logic                   frame_err
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic                   rxd_p0;
   logic                   rxd_s;
   logic                   rxd_s_d;
   rx_state_t              rx_state;
   rx_state_t              rx_state_nx;
   logic [CNT_W-1:0]       rx_cnt;
   logic [CNT_W-1:0]       rx_cnt_nx;
   logic [2:0]             rx_idx;
   logic [2:0]             rx_idx_nx;
   logic                   shift_en;
   logic                   valid_nx;
   logic                   ferr_nx;
   logic [UART_DATA_W-1:0] rx_shreg;

   // Two-flop synchronizer on rxd plus one delay flop for falling-edge detection.
   always_ff @(posedge clk11 or posedge rst) begin
      if (rst) begin
         rxd_p0  <= 1'b1;
         rxd_s   <= 1'b1;
         rxd_s_d <= 1'b1;
      end else begin
         rxd_p0  <= rxd;
         rxd_s   <= rxd_p0;
         rxd_s_d <= rxd_s;
      end
   end

   // RX control state; a reset mid-frame drops whatever was partially received.
   always_ff @(posedge clk11 or posedge rst) begin
      if (rst) begin
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_idx     <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_state   <= rx_state_nx;
         rx_cnt     <= rx_cnt_nx;
         rx_idx     <= rx_idx_nx;
         byte_valid <= valid_nx;
         frame_err  <= ferr_nx;
      end
   end

   // Next-state logic: half a bit to mid-start, then one full bit per sample.
   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = rx_cnt;
      rx_idx_nx   = rx_idx;
      shift_en    = 1'b0;
      valid_nx    = 1'b0;
      ferr_nx     = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rxd_s_d && !rxd_s) begin
               rx_state_nx = RX_START;
               rx_cnt_nx   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt == CNT_HALF) begin
               rx_cnt_nx   = '0;
               rx_idx_nx   = '0;
               // A line that is high again at mid-start was only a glitch.
               rx_state_nx = rxd_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_nx = rx_cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == CNT_LAST) begin
               rx_cnt_nx = '0;
               shift_en  = 1'b1;
               if (rx_idx == 3'd7) begin
                  rx_state_nx = RX_STOP;
               end else begin
                  rx_idx_nx = rx_idx + 1'b1;
               end
            end else begin
               rx_cnt_nx = rx_cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == CNT_LAST) begin
               rx_cnt_nx   = '0;
               rx_state_nx = RX_IDLE;
               if (rxd_s) begin
                  valid_nx = 1'b1;
               end else begin
                  ferr_nx = 1'b1;
               end
            end else begin
               rx_cnt_nx = rx_cnt + 1'b1;
            end
         end
         default: rx_state_nx = RX_IDLE;
      endcase
   end

   // LSB-first shift register; only qualified by byte_valid, so no reset needed.
   always_ff @(posedge clk11) begin
      if (shift_en) begin
         rx_shreg <= {rxd_s, rx_shreg[UART_DATA_W-1:1]};
      end
   end

   assign rx_byte = rx_shreg;

endmodule

// File: rtl/uart_port_responder.sv
// UART chip model on the host's 8-bit strobed bus: THR/TSR transmit path,
// RBR receive buffer, status flags and tri-state read-back.
module uart_port_responder
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                   clk11,
   input  logic                   rst,
   input  logic                   wrn,
   input  logic                   rdn,
   inout  wire  [UART_DATA_W-1:0] data,
   input  logic                   rxd,
   output logic                   txd,
   output logic                   tbre,
   output logic                   tsre,
   output logic                   data_ready,
   output logic                   rx_overrun,
   output logic                   rx_frame_err
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic                   wrn_p0;
   logic                   wrn_s;
   logic                   wrn_s_d;
   logic                   rdn_p0;
   logic                   rdn_s;
   logic                   rdn_s_d;
   logic                   wr_rise;
   logic                   rd_rise;
   logic                   wr_cap;
   logic                   rd_active;
   logic                   wr_pending;
   logic                   wr_commit;
   logic [UART_DATA_W-1:0] wr_latch;
   logic [UART_DATA_W-1:0] thr;
   logic [UART_DATA_W-1:0] tsr;
   logic [UART_DATA_W-1:0] rbr;

   tx_state_t              tx_state;
   tx_state_t              tx_state_nx;
   logic [CNT_W-1:0]       tx_cnt;
   logic [CNT_W-1:0]       tx_cnt_nx;
   logic [2:0]             tx_idx;
   logic [2:0]             tx_idx_nx;
   logic                   txd_nx;
   logic                   tbre_nx;
   logic                   tsre_nx;
   logic                   thr_ld;
   logic                   tsr_ld;
   logic                   tsr_shift;

   logic                   rx_valid;
   logic [UART_DATA_W-1:0] rx_byte;

   // Two-flop synchronizers on both strobes plus a delay flop for edge detection.
   always_ff @(posedge clk11 or posedge rst) begin
      if (rst) begin
         wrn_p0  <= 1'b1;
         wrn_s   <= 1'b1;
         wrn_s_d <= 1'b1;
         rdn_p0  <= 1'b1;
         rdn_s   <= 1'b1;
         rdn_s_d <= 1'b1;
      end else begin
         wrn_p0  <= wrn;
         wrn_s   <= wrn_p0;
         wrn_s_d <= wrn_s;
         rdn_p0  <= rdn;
         rdn_s   <= rdn_p0;
         rdn_s_d <= rdn_s;
      end
   end

   assign wr_rise   = wrn_s & ~wrn_s_d;
   assign rd_rise   = rdn_s & ~rdn_s_d;
   assign wr_cap    = ~wrn_s & rdn_s;
   assign rd_active = ~rdn_s & wrn_s;

   // A write only commits if the latch was actually loaded during this strobe,
   // so a strobe spent entirely with rdn also low writes nothing.
   assign wr_commit = wr_rise & wr_pending & tbre;

   // Tracks whether the current wrn pulse captured any bus data.
   always_ff @(posedge clk11 or posedge rst) begin
      if (rst) begin
         wr_pending <= 1'b0;
      end else if (wr_cap) begin
         wr_pending <= 1'b1;
      end else if (wrn_s) begin
         wr_pending <= 1'b0;
      end
   end

   // Write latch follows the bus for as long as the write strobe is held.
   always_ff @(posedge clk11) begin
      if (wr_cap) begin
         wr_latch <= data;
      end
   end

   // TX control state and line/status flags.
   always_ff @(posedge clk11 or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         txd      <= 1'b1;
         tbre     <= 1'b1;
         tsre     <= 1'b1;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_idx   <= tx_idx_nx;
         txd      <= txd_nx;
         tbre     <= tbre_nx;
         tsre     <= tsre_nx;
      end
   end

   // TX next-state: txd is registered, so each bit begins on the transition edge.
   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      tx_idx_nx   = tx_idx;
      txd_nx      = txd;
      tbre_nx     = tbre;
      tsre_nx     = tsre;
      thr_ld      = 1'b0;
      tsr_ld      = 1'b0;
      tsr_shift   = 1'b0;
      // Commit and THR->TSR transfer are exclusive: one needs tbre=1, the other tbre=0.
      if (wr_commit) begin
         thr_ld  = 1'b1;
         tbre_nx = 1'b0;
      end
      case (tx_state)
         TX_IDLE: begin
            txd_nx = 1'b1;
            if (!tbre) begin
               tx_state_nx = TX_START;
               tx_cnt_nx   = '0;
               tsr_ld      = 1'b1;
               tbre_nx     = 1'b1;
               tsre_nx     = 1'b0;
               txd_nx      = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt == CNT_LAST) begin
               tx_cnt_nx   = '0;
               tx_idx_nx   = '0;
               tx_state_nx = TX_DATA;
               txd_nx      = tsr[0];
            end else begin
               tx_cnt_nx = tx_cnt + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt == CNT_LAST) begin
               tx_cnt_nx = '0;
               if (tx_idx == 3'd7) begin
                  tx_state_nx = TX_STOP;
                  txd_nx      = 1'b1;
               end else begin
                  tx_idx_nx = tx_idx + 1'b1;
                  tsr_shift = 1'b1;
                  txd_nx    = tsr[1];
               end
            end else begin
               tx_cnt_nx = tx_cnt + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt == CNT_LAST) begin
               tx_cnt_nx = '0;
               if (!tbre) begin
                  // Next byte already waiting: chain frames with no idle bit.
                  tx_state_nx = TX_START;
                  tsr_ld      = 1'b1;
                  tbre_nx     = 1'b1;
                  txd_nx      = 1'b0;
               end else begin
                  tx_state_nx = TX_IDLE;
                  tsre_nx     = 1'b1;
                  txd_nx      = 1'b1;
               end
            end else begin
               tx_cnt_nx = tx_cnt + 1'b1;
            end
         end
         default: begin
            tx_state_nx = TX_IDLE;
            txd_nx      = 1'b1;
         end
      endcase
   end

   // Holding and shift registers; contents are only used when qualified by the FSM.
   always_ff @(posedge clk11) begin
      if (thr_ld) begin
         thr <= wr_latch;
      end
      if (tsr_ld) begin
         tsr <= thr;
      end else if (tsr_shift) begin
         tsr <= {1'b1, tsr[UART_DATA_W-1:1]};
      end
   end

   uart_rx_deserializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk11      (clk11),
      .rst        (rst),
      .rxd        (rxd),
      .byte_valid (rx_valid),
      .rx_byte    (rx_byte),
      .frame_err  (rx_frame_err)
   );

   // Receive status: a new byte beats a simultaneous read-clear. Overrun is only
   // flagged when the previous byte is still unread, not when it is being read now.
   always_ff @(posedge clk11 or posedge rst) begin
      if (rst) begin
         data_ready <= 1'b0;
         rx_overrun <= 1'b0;
      end else if (rx_valid) begin
         data_ready <= 1'b1;
         if (data_ready && !rd_rise) begin
            rx_overrun <= 1'b1;
         end
      end else if (rd_rise) begin
         data_ready <= 1'b0;
      end
   end

   // Receive buffer register, loaded only on a good stop bit.
   always_ff @(posedge clk11) begin
      if (rx_valid) begin
         rbr <= rx_byte;
      end
   end

   assign data = rd_active ? rbr : {UART_DATA_W{1'bz}};

endmodule
